// File: rtl/alu_issue_ctrl_if.sv
// Bundle of command, ALU-side and result signals for alu_issue_ctrl.
// The master modport is the environment: the command source, the ALU and the
// result consumer. The slave modport is the issue controller itself.
interface alu_issue_ctrl_if #(
    parameter int IN_DATA_WIDTH  = 16,
    parameter int OUT_DATA_WIDTH = 32
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [IN_DATA_WIDTH-1:0]  cmd_a;
    logic [IN_DATA_WIDTH-1:0]  cmd_b;
    logic [3:0]                cmd_fun;

    logic [IN_DATA_WIDTH-1:0]  alu_a;
    logic [IN_DATA_WIDTH-1:0]  alu_b;
    logic [3:0]                alu_fun;
    logic [OUT_DATA_WIDTH-1:0] alu_out;
    logic                      arith_flag;
    logic                      logic_flag;
    logic                      cmp_flag;
    logic                      shift_flag;

    logic                      res_valid;
    logic                      res_ready;
    logic [OUT_DATA_WIDTH-1:0] res_data;
    logic [3:0]                res_flags;
    logic                      res_err;
    logic                      busy;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_fun,
        input  cmd_ready,
        input  alu_a, alu_b, alu_fun,
        output alu_out, arith_flag, logic_flag, cmp_flag, shift_flag,
        input  res_valid, res_data, res_flags, res_err, busy,
        output res_ready
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_fun,
        output cmd_ready,
        output alu_a, alu_b, alu_fun,
        input  alu_out, arith_flag, logic_flag, cmp_flag, shift_flag,
        output res_valid, res_data, res_flags, res_err, busy,
        input  res_ready
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: queues ALU commands in a small FIFO, issues them one at a
// time to an external registered ALU and holds each result until consumed.
// Optional macro ALU_ISSUE_DIV0_CHECK_EN: rejects divide (fun 4'b0011) with a
// zero divisor without touching the ALU and reports it on res_err.
//
// state | meaning
// IDLE  | waiting for a queued command; pops and loads the ALU operands
// ISSUE | operands stable, ALU registers its result at the end of this cycle
// WAIT  | ALU result available, captured into the result registers
// HOLD  | result presented, waiting for res_ready
module alu_issue_ctrl #(
    parameter int IN_DATA_WIDTH  = 16,
    parameter int OUT_DATA_WIDTH = 32,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    alu_issue_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [3:0] FUN_NOP = 4'b1111;
    localparam logic [3:0] FUN_DIV = 4'b0011;

    logic [IN_DATA_WIDTH-1:0]  fifo_a_q   [FIFO_DEPTH];
    logic [IN_DATA_WIDTH-1:0]  fifo_b_q   [FIFO_DEPTH];
    logic [3:0]                fifo_fun_q [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]          count_q;

    state_t                    state_q, state_d;
    logic [IN_DATA_WIDTH-1:0]  alu_a_q, alu_a_d;
    logic [IN_DATA_WIDTH-1:0]  alu_b_q, alu_b_d;
    logic [3:0]                alu_fun_q, alu_fun_d;
    logic                      res_valid_q, res_valid_d;
    logic [OUT_DATA_WIDTH-1:0] res_data_q, res_data_d;
    logic [3:0]                res_flags_q, res_flags_d;

    logic                      push, pop, fifo_empty, reject;
    logic [IN_DATA_WIDTH-1:0]  head_a, head_b;
    logic [3:0]                head_fun;

    assign fifo_empty    = (count_q == '0);
    assign bus.cmd_ready = (count_q != CNT_FULL);
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign head_a        = fifo_a_q[rd_ptr_q];
    assign head_b        = fifo_b_q[rd_ptr_q];
    assign head_fun      = fifo_fun_q[rd_ptr_q];

`ifdef ALU_ISSUE_DIV0_CHECK_EN
    logic res_err_q, res_err_d;
    assign reject      = (head_fun == FUN_DIV) && (head_b == '0);
    assign bus.res_err = res_err_q;
`else
    assign reject      = 1'b0;
    assign bus.res_err = 1'b0;
`endif

    // Command FIFO storage, pointers and occupancy; pointers wrap naturally.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_a_q[i]   <= '0;
                fifo_b_q[i]   <= '0;
                fifo_fun_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_a_q[wr_ptr_q]   <= bus.cmd_a;
                fifo_b_q[wr_ptr_q]   <= bus.cmd_b;
                fifo_fun_q[wr_ptr_q] <= bus.cmd_fun;
                wr_ptr_q             <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // FSM state and ALU/result registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_fun_q   <= FUN_NOP;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_fun_q   <= alu_fun_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_flags_q <= res_flags_d;
        end
    end

`ifdef ALU_ISSUE_DIV0_CHECK_EN
    // Error flag accompanying the held result.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            res_err_q <= 1'b0;
        end else begin
            res_err_q <= res_err_d;
        end
    end
`endif

    // Next-state, FIFO pop and register updates for each FSM state.
    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_fun_d   = alu_fun_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_flags_d = res_flags_q;
        pop         = 1'b0;
`ifdef ALU_ISSUE_DIV0_CHECK_EN
        res_err_d   = res_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (reject) begin
                        // Rejected divide skips the ALU; operands stay as they were.
                        res_valid_d = 1'b1;
                        res_data_d  = '0;
                        res_flags_d = '0;
`ifdef ALU_ISSUE_DIV0_CHECK_EN
                        res_err_d   = 1'b1;
`endif
                        state_d     = S_HOLD;
                    end else begin
                        alu_a_d   = head_a;
                        alu_b_d   = head_b;
                        alu_fun_d = head_fun;
                        state_d   = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                res_data_d  = bus.alu_out;
                res_flags_d = {bus.shift_flag, bus.cmp_flag, bus.logic_flag, bus.arith_flag};
                res_valid_d = 1'b1;
`ifdef ALU_ISSUE_DIV0_CHECK_EN
                res_err_d   = 1'b0;
`endif
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    alu_fun_d   = FUN_NOP;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_fun   = alu_fun_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_flags = res_flags_q;
    assign bus.busy      = (state_q != S_IDLE) || !fifo_empty;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl with a registered ALU model and result scoreboard.
module tb_alu_issue_ctrl;
    localparam int INW  = 16;
    localparam int OUTW = 32;
`ifdef ALU_ISSUE_DIV0_CHECK_EN
    localparam bit DIV0 = 1'b1;
`else
    localparam bit DIV0 = 1'b0;
`endif

    typedef struct {
        logic [OUTW-1:0] data;
        logic [3:0]      flags;
        logic            err;
    } exp_t;

    typedef struct {
        logic [INW-1:0]  a;
        logic [INW-1:0]  b;
        logic [3:0]      fun;
        logic [OUTW-1:0] data;
        logic [3:0]      flags;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;
    exp_t exp_q[$];
    int   res_cyc[$];

    alu_issue_ctrl_if #(.IN_DATA_WIDTH(INW), .OUT_DATA_WIDTH(OUTW)) bus ();

    alu_issue_ctrl #(.IN_DATA_WIDTH(INW), .OUT_DATA_WIDTH(OUTW), .FIFO_DEPTH(4)) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered ALU model: 0-3 arith, 4-7 logic, 8-9 compare, 10-11 shift, else NOP.
    always @(posedge clk) begin
        bus.arith_flag <= 1'b0;
        bus.logic_flag <= 1'b0;
        bus.cmp_flag   <= 1'b0;
        bus.shift_flag <= 1'b0;
        case (bus.alu_fun)
            4'h0: begin bus.alu_out <= OUTW'(bus.alu_a) + OUTW'(bus.alu_b); bus.arith_flag <= 1'b1; end
            4'h1: begin bus.alu_out <= OUTW'(bus.alu_a) - OUTW'(bus.alu_b); bus.arith_flag <= 1'b1; end
            4'h2: begin bus.alu_out <= OUTW'(bus.alu_a) * OUTW'(bus.alu_b); bus.arith_flag <= 1'b1; end
            4'h3: begin
                bus.alu_out    <= (bus.alu_b == '0) ? '0 : OUTW'(bus.alu_a / bus.alu_b);
                bus.arith_flag <= 1'b1;
            end
            4'h4: begin bus.alu_out <= OUTW'(bus.alu_a & bus.alu_b); bus.logic_flag <= 1'b1; end
            4'h5: begin bus.alu_out <= OUTW'(bus.alu_a | bus.alu_b); bus.logic_flag <= 1'b1; end
            4'h6: begin bus.alu_out <= OUTW'(bus.alu_a ^ bus.alu_b); bus.logic_flag <= 1'b1; end
            4'h7: begin bus.alu_out <= OUTW'(~bus.alu_a);            bus.logic_flag <= 1'b1; end
            4'h8: begin bus.alu_out <= OUTW'(bus.alu_a <  bus.alu_b); bus.cmp_flag <= 1'b1; end
            4'h9: begin bus.alu_out <= OUTW'(bus.alu_a == bus.alu_b); bus.cmp_flag <= 1'b1; end
            4'hA: begin bus.alu_out <= OUTW'(bus.alu_a) << bus.alu_b[3:0]; bus.shift_flag <= 1'b1; end
            4'hB: begin bus.alu_out <= OUTW'(bus.alu_a) >> bus.alu_b[3:0]; bus.shift_flag <= 1'b1; end
            default: bus.alu_out <= '0;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Result monitor: samples just before each rising edge.
    task automatic monitor();
        exp_t            e;
        logic            held = 1'b0;
        logic [OUTW-1:0] hdata;
        logic [3:0]      hflags;
        logic            herr;
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) begin
                held = 1'b0;
            end else if (bus.res_valid && bus.res_ready) begin
                held = 1'b0;
                res_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", {32'h0, bus.res_data}, 64'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_data",  {32'h0, bus.res_data}, {32'h0, e.data});
                    chk("res_flags", {60'h0, bus.res_flags}, {60'h0, e.flags});
                    chk("res_err",   {63'h0, bus.res_err}, {63'h0, e.err});
                end
            end else if (bus.res_valid) begin
                if (held) begin
                    chk("hold_data",  {32'h0, bus.res_data}, {32'h0, hdata});
                    chk("hold_flags", {60'h0, bus.res_flags}, {60'h0, hflags});
                    chk("hold_err",   {63'h0, bus.res_err}, {63'h0, herr});
                end
                held   = 1'b1;
                hdata  = bus.res_data;
                hflags = bus.res_flags;
                herr   = bus.res_err;
            end else begin
                held = 1'b0;
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [INW-1:0] a, input logic [INW-1:0] b, input logic [3:0] fun,
                        input logic [OUTW-1:0] ed, input logic [3:0] ef, input logic ee,
                        input bit track);
        exp_t e;
        bit   ok = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_fun   = fun;
        for (int i = 0; i < 200; i++) begin
            if (bus.cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("cmd_ready_timeout", 64'h0, 64'h1);
        if (ok && track) begin
            e.data  = ed;
            e.flags = ef;
            e.err   = ee;
            exp_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (exp_q.size() == 0 && !bus.busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("drain_timeout", 64'(exp_q.size()), 64'h0);
        repeat (2) @(negedge clk);
    endtask

    vec_t vecs[10];
    int   accepted;

    initial begin
        vecs[0] = '{a: 16'd40,    b: 16'd20, fun: 4'b0000, data: 32'd60,      flags: 4'b0001};
        vecs[1] = '{a: 16'd40,    b: 16'd20, fun: 4'b0001, data: 32'd20,      flags: 4'b0001};
        vecs[2] = '{a: 16'd40,    b: 16'd20, fun: 4'b0010, data: 32'd800,     flags: 4'b0001};
        vecs[3] = '{a: 16'd40,    b: 16'd20, fun: 4'b0011, data: 32'd2,       flags: 4'b0001};
        vecs[4] = '{a: 16'd12,    b: 16'd10, fun: 4'b0100, data: 32'd8,       flags: 4'b0010};
        vecs[5] = '{a: 16'd12,    b: 16'd10, fun: 4'b0101, data: 32'd14,      flags: 4'b0010};
        vecs[6] = '{a: 16'd3,     b: 16'd20, fun: 4'b1000, data: 32'd1,       flags: 4'b0100};
        vecs[7] = '{a: 16'd5,     b: 16'd3,  fun: 4'b1010, data: 32'd40,      flags: 4'b1000};
        vecs[8] = '{a: 16'd40,    b: 16'd20, fun: 4'b1111, data: 32'd0,       flags: 4'b0000};
        vecs[9] = '{a: 16'hFFFF,  b: 16'd1,  fun: 4'b0000, data: 32'h0001_0000, flags: 4'b0001};

        checks        = 0;
        errors        = 0;
        cyc           = 0;
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_fun   = '0;
        bus.res_ready = 1'b1;
        fork
            monitor();
        join_none

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", {63'h0, bus.cmd_ready}, 64'h1);
        chk("rst_res_valid", {63'h0, bus.res_valid}, 64'h0);
        chk("rst_alu_fun",   {60'h0, bus.alu_fun},   64'hF);
        chk("rst_alu_a",     {48'h0, bus.alu_a},     64'h0);
        chk("rst_alu_b",     {48'h0, bus.alu_b},     64'h0);
        chk("rst_res_data",  {32'h0, bus.res_data},  64'h0);
        chk("rst_res_flags", {60'h0, bus.res_flags}, 64'h0);
        chk("rst_res_err",   {63'h0, bus.res_err},   64'h0);
        chk("rst_busy",      {63'h0, bus.busy},      64'h0);
        rst_n = 1'b1;

        // Latency: first push right after reset release, result three edges later
        send(16'd40, 16'd20, 4'b0000, 32'd60, 4'b0001, 1'b0, 1'b1);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("lat_e1_valid",   {63'h0, bus.res_valid}, 64'h0);
        chk("lat_e1_alu_a",   {48'h0, bus.alu_a},     64'd40);
        chk("lat_e1_alu_b",   {48'h0, bus.alu_b},     64'd20);
        chk("lat_e1_alu_fun", {60'h0, bus.alu_fun},   64'h0);
        @(negedge clk);
        chk("lat_e2_valid",   {63'h0, bus.res_valid}, 64'h0);
        @(negedge clk);
        chk("lat_e3_valid",   {63'h0, bus.res_valid}, 64'h1);
        drain();
        chk("nop_after_hold", {60'h0, bus.alu_fun}, 64'hF);

        // Table-driven vectors, back to back; results must be 4 cycles apart
        res_cyc.delete();
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].fun, vecs[i].data, vecs[i].flags, 1'b0, 1'b1);
        end
        bus.cmd_valid = 1'b0;
        drain();
        chk("table_result_count", 64'(res_cyc.size()), 64'd10);
        for (int i = 1; i < res_cyc.size(); i++) begin
            chk("throughput_spacing", 64'(res_cyc[i] - res_cyc[i-1]), 64'd4);
        end

        // Backpressure: one in flight plus four queued, then cmd_ready low
        bus.res_ready = 1'b0;
        accepted      = 0;
        for (int i = 0; i < 12; i++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_a     = 16'(accepted + 1);
            bus.cmd_b     = 16'd100;
            bus.cmd_fun   = 4'b0000;
            if (bus.cmd_ready) begin
                exp_q.push_back('{data: 32'(accepted + 101), flags: 4'b0001, err: 1'b0});
                accepted++;
            end
            @(negedge clk);
        end
        chk("bp_accepted",  64'(accepted), 64'd5);
        chk("bp_cmd_ready", {63'h0, bus.cmd_ready}, 64'h0);
        chk("bp_res_valid", {63'h0, bus.res_valid}, 64'h1);
        chk("bp_res_data",  {32'h0, bus.res_data},  64'd101);
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        drain();

        // Divide by zero
        send(16'd40, 16'd0, 4'b0011, 32'd0, DIV0 ? 4'b0000 : 4'b0001, DIV0, 1'b1);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("div0_valid_after_pop", {63'h0, bus.res_valid}, {63'h0, DIV0});
        chk("div0_alu_fun",         {60'h0, bus.alu_fun},   DIV0 ? 64'hF : 64'h3);
        @(negedge clk);
        chk("div0_alu_fun_hold",    {60'h0, bus.alu_fun},   DIV0 ? 64'hF : 64'h3);
        drain();

        // Reset while in WAIT with two commands queued
        send(16'd1, 16'd2, 4'b0000, 32'd0, 4'b0, 1'b0, 1'b0);
        send(16'd3, 16'd4, 4'b0000, 32'd0, 4'b0, 1'b0, 1'b0);
        send(16'd5, 16'd6, 4'b0000, 32'd0, 4'b0, 1'b0, 1'b0);
        bus.cmd_valid = 1'b0;
        chk("pre_rst_busy", {63'h0, bus.busy}, 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",      {63'h0, bus.busy},      64'h0);
        chk("mid_rst_res_valid", {63'h0, bus.res_valid}, 64'h0);
        chk("mid_rst_alu_fun",   {60'h0, bus.alu_fun},   64'hF);
        chk("mid_rst_alu_a",     {48'h0, bus.alu_a},     64'h0);
        chk("mid_rst_cmd_ready", {63'h0, bus.cmd_ready}, 64'h1);
        chk("mid_rst_res_data",  {32'h0, bus.res_data},  64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_busy", {63'h0, bus.busy}, 64'h0);

        // Normal operation resumes after reset
        send(16'd7, 16'd6, 4'b0010, 32'd42, 4'b0001, 1'b0, 1'b1);
        bus.cmd_valid = 1'b0;
        drain();
        chk("final_queue_empty", 64'(exp_q.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
